uinst_decode: RTL and testbench
===============================

# uinst_decode

Microcode store and decoder that sits on the other side of the `ucontrol` sequencer. It takes the registered `upc` and returns the per-instruction sequencing fields that drive `upc` next: `upc_up`, `upc_st` and `done`. It also holds the five loop-bound registers `loop_0`..`loop_4` and drives the datapath control word. A host-side load port writes the microcode store while the engine is idle.

## Interface
Parameters:
- `UINST_ADDR_WIDTH`, 8: microcode address width; the store depth is 2^UINST_ADDR_WIDTH.
- `UINST_WIDTH`, 32: microinstruction width. Fixed field map below; only 32 is supported.
- `CTRL_WIDTH`, 10: datapath control field width.

Ports:
- `clk`  in  1  — single clock.
- `rstn`  in  1  — asynchronous, active-low reset.
- `start_pos`  in  1  — one-cycle start pulse, shared with the sequencer.
- `upc`  in  UINST_ADDR_WIDTH  — current micro-PC from the sequencer.
- `upc_up`  out  3  — loop-back request to the sequencer.
- `upc_st`  out  3  — loop-start mark to the sequencer.
- `done`  out  1  — end-of-program pulse.
- `ctrl`  out  CTRL_WIDTH  — datapath control word.
- `loop_0`..`loop_4`  out  11 each  — loop bounds.
- `busy`  out  1  — program is running.
- `load_rst`  in  1  — resets the load write pointer to 0.
- `load_valid`  in  1  — load data qualifier.
- `load_data`  in  UINST_WIDTH  — microinstruction to store.
- `load_err`  out  1  — sticky error flag.

## Operation
- Field map of instruction word `w`:
  - [31:29] `upc_up`
  - [28:26] `upc_st`
  - [25] `DONE`
  - [24] `SETL`
  - [23:21] loop select
  - [20:10] loop value
  - [9:0] `ctrl`
- The store is a register array read combinationally at `upc`, so the sequencing fields always match the instruction currently at `upc`.
- `busy`:
  - Reset value 0.
  - Set on `start_pos`.
  - Cleared on the cycle after `done` is asserted.
  - If `start_pos` and `done` occur in the same cycle, `start_pos` wins and `busy` stays 1.
- While `busy=0`: `upc_up`, `upc_st`, `done` and `ctrl` are forced to 0 regardless of store contents.
- While `busy=1`: these outputs are the fields of `mem[upc]`, with `done = w[25]`.
- `SETL`:
  - Applies when `busy=1` and `w[24]=1`.
  - If select is 0..4, `loop_<sel>` takes the loop value at the clock edge.
  - Select 5..7 is ignored and sets `load_err`.
  - A loop value of 0 is still written but sets `load_err`; the sequencer's count would wrap.
- `SETL` has no bypass. A `SETL` and an `upc_st` for the same loop in one instruction load the OLD bound into the sequencer. The microcode must place `SETL` at least one instruction earlier.
- Loop registers hold their value across programs; only reset clears them.
- Load port:
  - Writes are accepted only when `busy=0`.
  - `load_rst` sets the write pointer to 0; it takes precedence over `load_valid` in the same cycle.
  - `load_valid` writes `mem[wptr] <= load_data` and increments `wptr`. `wptr` wraps from 2^UINST_ADDR_WIDTH−1 to 0 with no error.
  - `load_valid` while `busy=1` is dropped, leaves `wptr` unchanged, and sets `load_err`.
- `load_err` is sticky and is cleared only by `load_rst` or reset.
- Reset mid-program: `busy`, loop registers, `wptr` and `load_err` go to 0 immediately. The store contents are not reset.

## Timing
- Output reset values:
  - `upc_up`, `upc_st`, `done`, `ctrl`, `busy`: 0.
  - `loop_k`: 0.
  - `load_err`: 0.
- Decode latency is 0 cycles from `upc`, a combinational path into the sequencer's next-PC logic. Keep the read mux shallow.
- `SETL` effect is visible on `loop_k` 1 cycle after the instruction is at `upc`.
- Load write is visible on the combinational read 1 cycle after `load_valid`.
- `busy` rises 1 cycle after `start_pos` and is therefore aligned with the sequencer's own state bit. `done` is decoded from the instruction and is not registered.

## Structure
- Shared package `uinst_pkg`:
  - Field bit positions and widths.
  - `NUM_LOOPS=5`.
  - `LOOP_CNT_WIDTH=11`.
  - Loop-select encodings.
  - Sequencing codes `UP_L0..UP_L3 = 3'b100..3'b111`, `UP_L4 = 3'b011`, `NONE = 3'b000`; the same codes apply to `upc_st`.
- One natural sub-module: `uinst_store`, the register array with write pointer, load port and combinational read. Decode, `busy` and the loop registers stay in `uinst_decode`.

## Test plan
- Load 4 words via the load port after `load_rst`; with `busy=0`, set `upc=2` → all sequencing outputs 0. Then `start_pos`; with `upc=2` → `ctrl` equals `word2[9:0]`.
- Word0 `SETL` sel=1 val=3; word1 `upc_st=3'b101`; word2 `upc_up=3'b101`; word3 `DONE`. Run with `ucontrol` → `loop_1=3`; word2 is executed 2 times before falling through; `done` pulses once; `busy` drops the next cycle.
- `SETL` sel=6 val=5 → no `loop_k` changes and `load_err=1`. `load_rst` → `load_err=0`.
- `load_valid` while `busy=1` → store unchanged, `wptr` unchanged, `load_err=1`.
- Load 257 words with UINST_ADDR_WIDTH=8 → word 256 overwrites address 0.
- Assert `rstn` low mid-program with `loop_2=7` → `busy=0` and `loop_2=0` immediately; store contents preserved and readable after reset.

Source files
------------

// File: rtl/uinst_pkg.sv
// -----------------------------------------------------------------------------
// uinst_pkg
// Shared definitions for the microcode store / decoder pair:
//   - bit positions and widths of the 32-bit microinstruction fields
//   - loop-register count and loop-bound width
//   - loop-select encodings for the SETL field
//   - sequencing codes used on upc_up / upc_st
//   - a helper that splits a raw word into its named fields
// -----------------------------------------------------------------------------
package uinst_pkg;

  localparam int NUM_LOOPS      = 5;
  localparam int LOOP_CNT_WIDTH = 11;

  // Field map of the 32-bit microinstruction word
  localparam int UP_LSB    = 29;  // [31:29] upc_up
  localparam int UP_W      = 3;
  localparam int ST_LSB    = 26;  // [28:26] upc_st
  localparam int ST_W      = 3;
  localparam int DONE_BIT  = 25;  // [25]    DONE
  localparam int SETL_BIT  = 24;  // [24]    SETL
  localparam int LSEL_LSB  = 21;  // [23:21] loop select
  localparam int LSEL_W    = 3;
  localparam int LVAL_LSB  = 10;  // [20:10] loop value
  localparam int LVAL_W    = LOOP_CNT_WIDTH;
  localparam int CTRL_LSB  = 0;   // [9:0]   datapath control
  localparam int CTRL_W    = 10;
  localparam int UINST_W   = 32;

  // Loop-select encodings; 5..7 are reserved and flagged as errors
  typedef enum logic [LSEL_W-1:0] {
    LSEL_L0 = 3'd0,
    LSEL_L1 = 3'd1,
    LSEL_L2 = 3'd2,
    LSEL_L3 = 3'd3,
    LSEL_L4 = 3'd4
  } loop_sel_e;

  // Sequencing codes shared by upc_up and upc_st
  typedef enum logic [UP_W-1:0] {
    NONE  = 3'b000,
    UP_L4 = 3'b011,
    UP_L0 = 3'b100,
    UP_L1 = 3'b101,
    UP_L2 = 3'b110,
    UP_L3 = 3'b111
  } seq_code_e;

  typedef struct packed {
    logic [UP_W-1:0]   up;
    logic [ST_W-1:0]   st;
    logic              done;
    logic              setl;
    logic [LSEL_W-1:0] lsel;
    logic [LVAL_W-1:0] lval;
    logic [CTRL_W-1:0] ctrl;
  } uinst_t;

  function automatic uinst_t unpack_uinst(input logic [UINST_W-1:0] w);
    uinst_t u;
    u.up   = w[UP_LSB   +: UP_W];
    u.st   = w[ST_LSB   +: ST_W];
    u.done = w[DONE_BIT];
    u.setl = w[SETL_BIT];
    u.lsel = w[LSEL_LSB +: LSEL_W];
    u.lval = w[LVAL_LSB +: LVAL_W];
    u.ctrl = w[CTRL_LSB +: CTRL_W];
    return u;
  endfunction

  // True when the select addresses one of the implemented loop registers
  function automatic logic lsel_valid(input logic [LSEL_W-1:0] s);
    return (s <= LSEL_L4);
  endfunction

endpackage

// File: rtl/uinst_store.sv
// -----------------------------------------------------------------------------
// uinst_store
// Microcode register array with a host load port and a combinational read.
//
// Ports:
//   clk        in   clock
//   rstn       in   asynchronous active-low reset (write pointer only;
//                   the array contents survive reset)
//   busy       in   engine running; host writes are refused while high
//   load_rst   in   return write pointer to 0 (wins over load_valid)
//   load_valid in   write load_data at the write pointer, then advance
//   load_data  in   microinstruction to store
//   raddr      in   read address (the sequencer's upc)
//   rdata      out  mem[raddr], combinational
//   load_drop  out  a load_valid was refused because busy=1
// -----------------------------------------------------------------------------
module uinst_store
  import uinst_pkg::*;
#(
  parameter int UINST_ADDR_WIDTH = 8,
  parameter int UINST_WIDTH      = 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        busy,
  input  logic                        load_rst,
  input  logic                        load_valid,
  input  logic [UINST_WIDTH-1:0]      load_data,
  input  logic [UINST_ADDR_WIDTH-1:0] raddr,
  output logic [UINST_WIDTH-1:0]      rdata,
  output logic                        load_drop
);

  localparam int DEPTH = 1 << UINST_ADDR_WIDTH;

  logic [UINST_WIDTH-1:0]      mem [DEPTH];
  logic [UINST_ADDR_WIDTH-1:0] wptr;
  logic                        wr_en;

  // load_rst suppresses any write in the same cycle
  assign wr_en     = load_valid & ~load_rst & ~busy;
  assign load_drop = load_valid & ~load_rst &  busy;

  // Pointer wraps naturally at 2^UINST_ADDR_WIDTH; that is not an error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
    end else if (load_rst) begin
      wptr <= '0;
    end else if (wr_en) begin
      wptr <= wptr + 1'b1;
    end
  end

  // Array is deliberately outside the reset domain so a program survives
  // an engine reset and can be rerun without reloading.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= load_data;
    end
  end

  // Single-level read mux: this feeds the sequencer's next-PC logic
  assign rdata = mem[raddr];

endmodule

// File: rtl/uinst_decode.sv
// -----------------------------------------------------------------------------
// uinst_decode
// Microcode store plus decoder for the ucontrol sequencer. Returns the
// sequencing fields of the instruction at upc with zero latency, keeps the
// five loop-bound registers, drives the datapath control word and tracks
// whether a program is running.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start_pos            one-cycle start pulse (shared with the sequencer)
//   upc                  current micro-PC
//   upc_up, upc_st       loop-back request / loop-start mark (0 when idle)
//   done                 end-of-program pulse (0 when idle)
//   ctrl                 datapath control word (0 when idle)
//   loop_0..loop_4       loop bounds written by SETL instructions
//   busy                 program running
//   load_rst             reset load pointer, clear load_err
//   load_valid/load_data host write into the store (idle only)
//   load_err             sticky error flag
// -----------------------------------------------------------------------------
module uinst_decode
  import uinst_pkg::*;
#(
  parameter int UINST_ADDR_WIDTH = 8,
  parameter int UINST_WIDTH      = 32,
  parameter int CTRL_WIDTH       = 10
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start_pos,
  input  logic [UINST_ADDR_WIDTH-1:0] upc,
  output logic [2:0]                  upc_up,
  output logic [2:0]                  upc_st,
  output logic                        done,
  output logic [CTRL_WIDTH-1:0]       ctrl,
  output logic [LOOP_CNT_WIDTH-1:0]   loop_0,
  output logic [LOOP_CNT_WIDTH-1:0]   loop_1,
  output logic [LOOP_CNT_WIDTH-1:0]   loop_2,
  output logic [LOOP_CNT_WIDTH-1:0]   loop_3,
  output logic [LOOP_CNT_WIDTH-1:0]   loop_4,
  output logic                        busy,
  input  logic                        load_rst,
  input  logic                        load_valid,
  input  logic [UINST_WIDTH-1:0]      load_data,
  output logic                        load_err
);

  // The field map is fixed; reject other widths at elaboration
  if (UINST_WIDTH != UINST_W || CTRL_WIDTH != CTRL_W) begin : g_width_check
    $error("uinst_decode supports only UINST_WIDTH=32 and CTRL_WIDTH=10");
  end

  logic [UINST_WIDTH-1:0]    w_raw;
  uinst_t                    w;
  logic                      load_drop;
  logic                      setl_fire;
  logic                      setl_err;
  logic [LOOP_CNT_WIDTH-1:0] loop_q [NUM_LOOPS];

  uinst_store #(
    .UINST_ADDR_WIDTH (UINST_ADDR_WIDTH),
    .UINST_WIDTH      (UINST_WIDTH)
  ) u_store (
    .clk        (clk),
    .rstn       (rstn),
    .busy       (busy),
    .load_rst   (load_rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .raddr      (upc),
    .rdata      (w_raw),
    .load_drop  (load_drop)
  );

  assign w = unpack_uinst(w_raw);

  // Idle gating: stale store contents must never reach the sequencer
  assign upc_up = busy ? w.up   : NONE;
  assign upc_st = busy ? w.st   : NONE;
  assign done   = busy & w.done;
  assign ctrl   = busy ? w.ctrl : '0;

  // Run flag. start_pos wins over a coincident done so a back-to-back
  // restart keeps running.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= 1'b0;
    end else if (start_pos) begin
      busy <= 1'b1;
    end else if (done) begin
      busy <= 1'b0;
    end
  end

  // SETL writes the bound at the edge, so an upc_st in the same instruction
  // still sees the old bound. A zero bound is stored but flagged because
  // the sequencer's down-count would wrap.
  assign setl_fire = busy & w.setl;
  assign setl_err  = setl_fire & (~lsel_valid(w.lsel) | (w.lval == '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_LOOPS; k++) begin
        loop_q[k] <= '0;
      end
    end else if (setl_fire) begin
      for (int k = 0; k < NUM_LOOPS; k++) begin
        if (w.lsel == LSEL_W'(k)) begin
          loop_q[k] <= w.lval;
        end
      end
    end
  end

  assign loop_0 = loop_q[0];
  assign loop_1 = loop_q[1];
  assign loop_2 = loop_q[2];
  assign loop_3 = loop_q[3];
  assign loop_4 = loop_q[4];

  // Sticky error: load_rst clears it, but a new error in the same cycle is
  // kept so it cannot be lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_err <= 1'b0;
    end else begin
      load_err <= (load_err & ~load_rst) | setl_err | load_drop;
    end
  end

endmodule

// File: tb/tb_uinst_decode.sv
module tb_uinst_decode;

  logic        clk;
  logic        rstn;
  logic        start_pos;
  logic [7:0]  upc;
  logic [2:0]  upc_up;
  logic [2:0]  upc_st;
  logic        done;
  logic [9:0]  ctrl;
  logic [10:0] loop_0, loop_1, loop_2, loop_3, loop_4;
  logic        busy;
  logic        load_rst;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_err;

  uinst_decode #(
    .UINST_ADDR_WIDTH (8),
    .UINST_WIDTH      (32),
    .CTRL_WIDTH       (10)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_pos  (start_pos),
    .upc        (upc),
    .upc_up     (upc_up),
    .upc_st     (upc_st),
    .done       (done),
    .ctrl       (ctrl),
    .loop_0     (loop_0),
    .loop_1     (loop_1),
    .loop_2     (loop_2),
    .loop_3     (loop_3),
    .loop_4     (loop_4),
    .busy       (busy),
    .load_rst   (load_rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- upc source: manual or a small sequencer model --------
  logic       seq_en;
  logic [7:0] man_upc;
  logic [7:0] seq_upc;
  logic [7:0] seq_start;
  logic [10:0] seq_cnt;

  assign upc = seq_en ? seq_upc : man_upc;

  function automatic logic [10:0] bound_of(input logic [2:0] code);
    case (code)
      3'b100:  return loop_0;
      3'b101:  return loop_1;
      3'b110:  return loop_2;
      3'b111:  return loop_3;
      3'b011:  return loop_4;
      default: return 11'd0;
    endcase
  endfunction

  // Loop body (start..up) executes bound-1 times, then falls through
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seq_upc   <= 8'd0;
      seq_start <= 8'd0;
      seq_cnt   <= 11'd0;
    end else if (start_pos) begin
      seq_upc <= 8'd0;
    end else if (busy && seq_en) begin
      if (upc_st != 3'b000) begin
        seq_start <= seq_upc + 8'd1;
        seq_cnt   <= bound_of(upc_st) - 11'd1;
      end
      if (upc_up != 3'b000 && seq_cnt > 11'd1) begin
        seq_cnt <= seq_cnt - 11'd1;
        seq_upc <= seq_start;
      end else begin
        seq_upc <= seq_upc + 8'd1;
      end
    end
  end

  // Run monitor, sampled on the falling edge
  int   exec2;
  int   done_cnt;
  logic prev_done;
  logic busy_after_done;

  always @(negedge clk) begin
    if (seq_en) begin
      if (prev_done) busy_after_done = busy;
      if (busy && upc == 8'd2) exec2++;
      if (done) done_cnt++;
      prev_done = done;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_pos = 1'b1;
    tick();
    start_pos = 1'b0;
  endtask

  task automatic do_load_rst();
    load_rst = 1'b1;
    tick();
    load_rst = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic run_seq(input string name);
    logic idle;
    exec2 = 0;
    done_cnt = 0;
    prev_done = 1'b0;
    busy_after_done = 1'b1;
    seq_en = 1'b1;
    pulse_start();
    idle = 1'b0;
    for (int c = 0; c < 50 && !idle; c++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    @(negedge clk);
    #1;
    if (!idle) check({name, "_timeout"}, 64'd0, 64'd1);
    seq_en = 1'b0;
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [31:0] word;
    logic [2:0]  up;
    logic [2:0]  st;
    logic [9:0]  ctrl;
  } vec_t;

  vec_t tbl [6];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h8000_0001, 3'b100, 3'b000, 10'h001};
    tbl[1] = '{32'h1C00_03FF, 3'b000, 3'b111, 10'h3FF};
    tbl[2] = '{32'h6C00_0200, 3'b011, 3'b011, 10'h200};
    tbl[3] = '{32'hF000_00AA, 3'b111, 3'b100, 10'h0AA};
    tbl[4] = '{32'h00FF_FD55, 3'b000, 3'b000, 10'h155};  // select/value bits set, SETL clear
    tbl[5] = '{32'hD400_0000, 3'b110, 3'b101, 10'h000};

    rstn = 1'b0; start_pos = 1'b0; load_rst = 1'b0; load_valid = 1'b0;
    load_data = '0; man_upc = '0; seq_en = 1'b0;
    exec2 = 0; done_cnt = 0; prev_done = 1'b0; busy_after_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // Reset state
    check("rst_seq_outs", 64'({upc_up, upc_st, done, ctrl}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_loops", 64'({loop_0, loop_1, loop_2, loop_3, loop_4}), 64'd0);
    check("rst_load_err", 64'(load_err), 64'd0);

    // Table: load, check idle gating, then decode while busy
    do_load_rst();
    for (int i = 0; i < 6; i++) load_word(tbl[i].word);
    load_word(32'h0200_0000);  // addr 6: DONE
    for (int i = 0; i < 6; i++) begin
      man_upc = 8'(i);
      #1;
      check($sformatf("idle_gate_%0d", i), 64'({upc_up, upc_st, done, ctrl}), 64'd0);
    end
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < 6; i++) begin
      man_upc = 8'(i);
      #1;
      check($sformatf("decode_%0d", i), 64'({upc_up, upc_st, done, ctrl}),
            64'({tbl[i].up, tbl[i].st, 1'b0, tbl[i].ctrl}));
    end
    man_upc = 8'd6;
    #1;
    check("done_decode", 64'({done, ctrl}), 64'({1'b1, 10'h000}));
    tick();
    check("busy_clear_after_done", 64'(busy), 64'd0);
    check("table_no_err", 64'(load_err), 64'd0);

    // Loop program
    do_load_rst();
    load_word(32'h0120_0C00);  // SETL sel=1 val=3
    load_word(32'h1400_0011);  // upc_st = L1
    load_word(32'hA000_02AB);  // upc_up = L1
    load_word(32'h0200_03C5);  // DONE
    man_upc = 8'd2;
    #1;
    check("prog_idle_gate", 64'({upc_up, upc_st, done, ctrl}), 64'd0);
    pulse_start();
    check("prog_word2_ctrl", 64'(ctrl), 64'h2AB);
    man_upc = 8'd3;
    #1;
    tick();
    check("prog_manual_stop", 64'(busy), 64'd0);
    run_seq("prog");
    check("prog_loop_1", 64'(loop_1), 64'd3);
    check("prog_word2_execs", 64'(exec2), 64'd2);
    check("prog_done_pulses", 64'(done_cnt), 64'd1);
    check("prog_busy_after_done", 64'(busy_after_done), 64'd0);
    check("prog_no_err", 64'(load_err), 64'd0);

    // SETL with reserved select
    do_load_rst();
    load_word(32'h01C0_1400);  // SETL sel=6 val=5
    load_word(32'h0200_0000);  // DONE
    run_seq("bad_sel");
    check("bad_sel_loop_0", 64'(loop_0), 64'd0);
    check("bad_sel_loop_1", 64'(loop_1), 64'd3);
    check("bad_sel_loop_2", 64'(loop_2), 64'd0);
    check("bad_sel_loop_3", 64'(loop_3), 64'd0);
    check("bad_sel_loop_4", 64'(loop_4), 64'd0);
    check("bad_sel_err", 64'(load_err), 64'd1);
    do_load_rst();
    check("err_cleared", 64'(load_err), 64'd0);

    // load_valid while busy is dropped
    load_word(32'h0000_0001);
    load_word(32'h0200_0000);
    man_upc = 8'd0;
    #1;
    pulse_start();
    load_word(32'hDEAD_BEEF);
    check("busy_load_err", 64'(load_err), 64'd1);
    man_upc = 8'd1;
    #1;
    tick();
    load_word(32'h0000_0155);  // should land at address 2
    man_upc = 8'd0;
    #1;
    pulse_start();
    check("busy_load_mem0", 64'(ctrl), 64'h001);
    man_upc = 8'd2;
    #1;
    check("busy_load_wptr", 64'(ctrl), 64'h155);
    man_upc = 8'd1;
    #1;
    tick();
    check("err_sticky", 64'(load_err), 64'd1);

    // Pointer wrap: 257 words, then a SETL word at address 1
    do_load_rst();
    for (int i = 0; i < 256; i++) load_word(32'(i));
    load_word(32'h0000_0300);  // wraps to address 0
    load_word(32'h0140_1C00);  // address 1: SETL sel=2 val=7
    check("wrap_no_err", 64'(load_err), 64'd0);
    man_upc = 8'd0;
    #1;
    pulse_start();
    check("wrap_addr0", 64'(ctrl), 64'h300);
    man_upc = 8'd255;
    #1;
    check("wrap_addr255", 64'(ctrl), 64'h0FF);
    man_upc = 8'd1;
    #1;
    tick();
    check("setl_loop_2", 64'(loop_2), 64'd7);
    man_upc = 8'd2;
    #1;
    check("mid_prog_ctrl", 64'(ctrl), 64'h002);

    // Asynchronous reset mid-program
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_loop_2", 64'(loop_2), 64'd0);
    check("arst_loop_1", 64'(loop_1), 64'd0);
    check("arst_outs", 64'({upc_up, upc_st, done, ctrl}), 64'd0);
    #1 rstn = 1'b1;
    tick();
    pulse_start();
    check("keep_addr2", 64'(ctrl), 64'h002);
    man_upc = 8'd0;
    #1;
    check("keep_addr0", 64'(ctrl), 64'h300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
